// File: rtl/npu_add_tree_pkg.sv
// rtl/npu_add_tree_pkg.sv - shared widths and state encoding for the add-tree sequencer
package npu_add_tree_pkg;
  localparam int DWA      = 8;
  localparam int MAC_NUM  = 8;
  localparam int DWOUPUT  = 19;
  localparam int DWACC    = 28;
  localparam int LENW     = 12;
  localparam int TREE_LAT = 3;
  localparam int DW_LANES = DWA * MAC_NUM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/npu_add_tree_seq_if.sv
// rtl/npu_add_tree_seq_if.sv - job, operand, tree and result signals of the sequencer
interface npu_add_tree_seq_if;
  import npu_add_tree_pkg::*;

  logic                start;
  logic [LENW-1:0]     k_len;
  logic                is_signed_in;
  logic                abort;
  logic                in_valid;
  logic                in_ready;
  logic [DW_LANES-1:0] in_data;
  logic [DW_LANES-1:0] in_para;
  logic [DW_LANES-1:0] tree_data;
  logic [DW_LANES-1:0] tree_para;
  logic                tree_is_signed;
  logic                tree_vld_o;
  logic [DWOUPUT-1:0]  tree_result_i;
  logic                res_valid;
  logic                res_ready;
  logic [DWACC-1:0]    res_data;
  logic                busy;

  modport master (
    output start, k_len, is_signed_in, abort, in_valid, in_data, in_para,
           tree_result_i, res_ready,
    input  in_ready, tree_data, tree_para, tree_is_signed, tree_vld_o,
           res_valid, res_data, busy
  );

  modport slave (
    input  start, k_len, is_signed_in, abort, in_valid, in_data, in_para,
           tree_result_i, res_ready,
    output in_ready, tree_data, tree_para, tree_is_signed, tree_vld_o,
           res_valid, res_data, busy
  );
endinterface

// File: rtl/npu_tag_pipe.sv
// rtl/npu_tag_pipe.sv - tracks live beats through the fixed-latency tree
module npu_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_tag,
  output logic tail,
  output logic empty
);
  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else if (clr) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], in_tag};
    end
  end

  // empty means no tag is still travelling ahead of the tail stage
  assign tail  = stages[DEPTH-1];
  assign empty = ~|stages[DEPTH-2:0];
endmodule

// File: rtl/npu_add_tree_seq.sv
// rtl/npu_add_tree_seq.sv - K-beat dot-product job sequencer around the 8-lane add tree
module npu_add_tree_seq
  import npu_add_tree_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  npu_add_tree_seq_if.slave  bus
);
  state_t           state;
  logic [LENW-1:0]  k_len_r;
  logic [LENW-1:0]  beat_cnt;
  logic [DWACC-1:0] acc;
  logic [DWACC-1:0] acc_next;
  logic [DWACC-1:0] tree_ext;
  logic             tag_tail;
  logic             tag_empty;
  logic             accept;
  logic             last_beat;
  logic             drain_done;

  npu_tag_pipe #(.DEPTH(TREE_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (bus.abort),
    .in_tag (bus.tree_vld_o),
    .tail   (tag_tail),
    .empty  (tag_empty)
  );

  assign accept     = bus.in_valid && bus.in_ready;
  assign last_beat  = accept && (beat_cnt == (k_len_r - LENW'(1)));
  assign tree_ext   = {{(DWACC-DWOUPUT){bus.tree_is_signed & bus.tree_result_i[DWOUPUT-1]}},
                       bus.tree_result_i};
  assign acc_next   = tag_tail ? (acc + tree_ext) : acc;
  // the final tag may still sit at the tail; it is folded in on the DONE entry edge
  assign drain_done = (state == DRAIN) && !bus.tree_vld_o && tag_empty;
  assign bus.busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      k_len_r            <= '0;
      beat_cnt           <= '0;
      acc                <= '0;
      bus.in_ready       <= 1'b0;
      bus.tree_data      <= '0;
      bus.tree_para      <= '0;
      bus.tree_is_signed <= 1'b0;
      bus.tree_vld_o     <= 1'b0;
      bus.res_valid      <= 1'b0;
      bus.res_data       <= '0;
    end else if (bus.abort) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      acc            <= '0;
      bus.in_ready   <= 1'b0;
      bus.tree_vld_o <= 1'b0;
      bus.res_valid  <= 1'b0;
    end else begin
      acc            <= acc_next;
      bus.tree_vld_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            k_len_r            <= bus.k_len;
            beat_cnt           <= '0;
            acc                <= '0;
            bus.tree_is_signed <= bus.is_signed_in;
            if (bus.k_len == '0) begin
              state         <= DONE;
              bus.res_data  <= '0;
              bus.res_valid <= 1'b1;
            end else begin
              state        <= RUN;
              bus.in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            bus.tree_data  <= bus.in_data;
            bus.tree_para  <= bus.in_para;
            bus.tree_vld_o <= 1'b1;
            beat_cnt       <= beat_cnt + LENW'(1);
            if (last_beat) begin
              state        <= DRAIN;
              bus.in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state         <= DONE;
            bus.res_data  <= acc_next;
            bus.res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_add_tree_seq.sv
// tb/tb_npu_add_tree_seq.sv - directed self-checking bench with a 3-cycle behavioural tree
module tb_npu_add_tree_seq;
  import npu_add_tree_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  npu_add_tree_seq_if bus ();

  npu_add_tree_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DWOUPUT-1:0] tree_sum(input logic [DW_LANES-1:0] d,
                                                  input logic [DW_LANES-1:0] p,
                                                  input logic sgn);
    int s = 0;
    for (int i = 0; i < MAC_NUM; i++) begin
      if (sgn) s += $signed(d[i*DWA +: DWA]) * $signed(p[i*DWA +: DWA]);
      else     s += int'(d[i*DWA +: DWA]) * int'(p[i*DWA +: DWA]);
    end
    return s[DWOUPUT-1:0];
  endfunction

  // behavioural tree: result of the beat shown on tree_data appears TREE_LAT cycles later
  logic [DWOUPUT-1:0] r0 = '0, r1 = '0, r2 = '0;
  always @(posedge clk) begin
    r0 <= tree_sum(bus.tree_data, bus.tree_para, bus.tree_is_signed);
    r1 <= r0;
    r2 <= r1;
  end
  assign bus.tree_result_i = r2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input int k, input logic sgn,
                         input logic [7:0] d, input logic [7:0] p, input logic [15:0] pat,
                         input logic [DWACC-1:0] exp_res, input int exp_lat, input int exp_beats);
    int n;
    int beats;
    bus.k_len        = LENW'(k);
    bus.is_signed_in = sgn;
    bus.in_data      = {MAC_NUM{d}};
    bus.in_para      = {MAC_NUM{p}};
    bus.in_valid     = 1'b0;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'(k != 0));
    n = 0;
    beats = 0;
    while (!bus.res_valid && n < 40) begin
      bus.in_valid = (n < 16) ? pat[n] : 1'b0;
      tick();
      n++;
      if (bus.tree_vld_o) beats++;
    end
    bus.in_valid = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " beats"}, 64'(beats), 64'(exp_beats));
    check({tag, " res_data"}, 64'(bus.res_data), 64'(exp_res));
  endtask

  task automatic accept_res(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, " accepted"}, {62'd0, bus.res_valid, bus.busy}, 64'd0);
  endtask

  initial begin
    logic stable;
    logic saw_res;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.is_signed_in = 1'b0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_para = '0;
    bus.res_ready = 1'b0;

    repeat (3) tick();
    check("reset ctrl", {59'd0, bus.in_ready, bus.tree_vld_o, bus.res_valid, bus.busy,
                         bus.tree_is_signed}, 64'd0);
    check("reset res_data", 64'(bus.res_data), 64'd0);
    check("reset tree_data", bus.tree_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // 4 beats of 8 lanes x (1*2) = 64
    run_job("t1", 4, 1'b0, 8'd1, 8'd2, 16'hFFFF, 28'd64, 8, 4);
    accept_res("t1");

    // 3 signed beats of 8 x (-1*5) = -120, gaps between beats
    run_job("t2", 3, 1'b1, 8'hFF, 8'h05, 16'h0015, 28'hFFFFF88, 9, 3);
    check("t2 signed", 64'(bus.tree_is_signed), 64'd1);
    accept_res("t2");

    run_job("t3", 0, 1'b0, 8'd7, 8'd7, 16'hFFFF, 28'd0, 0, 0);
    accept_res("t3");

    // result held under back-pressure; starts in DONE and on the accept edge are ignored
    run_job("t4", 2, 1'b0, 8'd3, 8'd4, 16'hFFFF, 28'd192, 6, 2);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 4);
      bus.k_len = LENW'(5);
      tick();
      if (!(bus.res_data === 28'd192 && bus.res_valid === 1'b1 && bus.busy === 1'b1)) stable = 1'b0;
    end
    bus.start = 1'b0;
    check("t4 hold", 64'(stable), 64'd1);
    bus.res_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    check("t4 start on accept", {62'd0, bus.busy, bus.res_valid}, 64'd0);
    repeat (3) tick();
    check("t4 single result", {61'd0, bus.busy, bus.res_valid, bus.in_ready}, 64'd0);

    // abort after two of five beats
    bus.k_len = LENW'(5);
    bus.is_signed_in = 1'b0;
    bus.in_data = {MAC_NUM{8'd9}};
    bus.in_para = {MAC_NUM{8'd9}};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5 abort", {60'd0, bus.busy, bus.in_ready, bus.res_valid, bus.tree_vld_o}, 64'd0);
    saw_res = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) saw_res = 1'b1;
    end
    check("t5 quiet", 64'(saw_res), 64'd0);
    run_job("t5b", 1, 1'b0, 8'd2, 8'd2, 16'hFFFF, 28'd32, 5, 1);
    accept_res("t5b");

    // asynchronous reset while draining
    bus.k_len = LENW'(3);
    bus.is_signed_in = 1'b1;
    bus.in_data = {MAC_NUM{8'd1}};
    bus.in_para = {MAC_NUM{8'd1}};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    tick();
    check("t6 in drain", {62'd0, bus.busy, bus.in_ready}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 reset ctrl", {59'd0, bus.in_ready, bus.tree_vld_o, bus.res_valid, bus.busy,
                            bus.tree_is_signed}, 64'd0);
    check("t6 reset data", {8'd0, bus.res_data, bus.tree_para[27:0]}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6 idle after release", {61'd0, bus.busy, bus.in_ready, bus.res_valid}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
